// File: rtl/morse_tx_pkg.sv
// Shared definitions for the Morse transmitter: FSM states, status codes,
// interval lengths in Morse units and r29 field positions.
package morse_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MARK,
    S_SPACE,
    S_GAP,
    S_DONE,
    S_ERR,
    S_WAIT_CLR
  } state_t;

  localparam logic [31:0] STATUS_DONE = 32'h1;
  localparam logic [31:0] STATUS_ERR  = 32'h2;

  localparam logic [2:0] DOT_UNITS  = 3'd1;
  localparam logic [2:0] DASH_UNITS = 3'd3;
  localparam logic [2:0] ELEM_GAP   = 3'd1;
  localparam logic [2:0] LETTER_GAP = 3'd3;
  localparam logic [2:0] WORD_GAP   = 3'd7;

  localparam int unsigned GO_BIT   = 31;
  localparam int unsigned WORD_BIT = 30;
  localparam int unsigned PAT_LSB  = 3;
  localparam int unsigned PAT_W    = 6;
  localparam int unsigned LEN_LSB  = 0;
  localparam int unsigned LEN_W    = 3;

endpackage

// File: rtl/morse_tx_if.sv
// r29/r30 link between the register file side and the Morse transmitter,
// plus the key line and busy flag.
interface morse_tx_if;
  logic [31:0] data_r29;
  logic [31:0] data_r30;
  logic        key_out;
  logic        busy;

  modport master (output data_r29, input data_r30, input key_out, input busy);
  modport slave  (input data_r29, output data_r30, output key_out, output busy);
endinterface

// File: rtl/morse_unit_timer.sv
// Interval timer: a cycle prescaler producing a tick every UNIT_CYCLES
// clocks, and a unit counter that flags the last cycle of a target-unit
// interval. Counters restart on clear and automatically after done.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [2:0] target,
  output logic       done
);
  localparam int unsigned CW = $clog2(7 * UNIT_CYCLES) + 1;

  logic [CW-1:0] cyc;
  logic [2:0]    units;
  logic          tick;

  assign tick = (cyc == CW'(UNIT_CYCLES - 1));
  assign done = tick && (units == target - 3'd1);

  // Prescaler and unit count; restart at each interval boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc   <= '0;
      units <= '0;
    end else if (clear || done) begin
      cyc   <= '0;
      units <= '0;
    end else if (tick) begin
      cyc   <= '0;
      units <= units + 3'd1;
    end else begin
      cyc <= cyc + 1'b1;
    end
  end
endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: plays the symbol written to r29 on key_out and posts a
// one-cycle status word on data_r30 when finished or on a bad length.
module morse_tx
  import morse_tx_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter int unsigned MAX_ELEM    = 6
) (
  input  logic       clock,
  input  logic       ctrl_reset,
  morse_tx_if.slave  bus
);
  state_t           state;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  logic             word;
  logic             key_q;
  logic             busy_q;
  logic [31:0]      status_q;

  logic             tmr_clear;
  logic [2:0]       tmr_target;
  logic             tmr_done;

  logic             r29_go;
  logic             r29_word;
  logic [PAT_W-1:0] r29_pat;
  logic [LEN_W-1:0] r29_len;
  logic             unused_r29;

  assign r29_go     = bus.data_r29[GO_BIT];
  assign r29_word   = bus.data_r29[WORD_BIT];
  assign r29_pat    = bus.data_r29[PAT_LSB +: PAT_W];
  assign r29_len    = bus.data_r29[LEN_LSB +: LEN_W];
  assign unused_r29 = ^bus.data_r29[WORD_BIT-1:PAT_LSB+PAT_W];

  assign bus.key_out  = key_q;
  assign bus.busy     = busy_q;
  assign bus.data_r30 = status_q;

  // Timer runs only in timed states; held cleared elsewhere so every timed
  // state starts from zero
  always_comb begin
    tmr_clear  = 1'b1;
    tmr_target = DOT_UNITS;
    case (state)
      S_MARK: begin
        tmr_clear  = 1'b0;
        tmr_target = pat[idx] ? DASH_UNITS : DOT_UNITS;
      end
      S_SPACE: begin
        tmr_clear  = 1'b0;
        tmr_target = ELEM_GAP;
      end
      S_GAP: begin
        tmr_clear  = 1'b0;
        tmr_target = word ? WORD_GAP : LETTER_GAP;
      end
      default: ;
    endcase
  end

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk    (clock),
    .rst_n  (ctrl_reset),
    .clear  (tmr_clear),
    .target (tmr_target),
    .done   (tmr_done)
  );

  // Symbol sequencer; outputs are registered from the current state, so they
  // trail the state by one cycle while every interval keeps its exact length
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state    <= S_IDLE;
      pat      <= '0;
      len      <= '0;
      idx      <= '0;
      word     <= 1'b0;
      key_q    <= 1'b0;
      busy_q   <= 1'b0;
      status_q <= '0;
    end else begin
      key_q    <= (state == S_MARK);
      busy_q   <= (state != S_IDLE);
      status_q <= (state == S_DONE) ? STATUS_DONE :
                  (state == S_ERR)  ? STATUS_ERR  : '0;
      case (state)
        S_IDLE: if (r29_go) state <= S_LOAD;
        S_LOAD: begin
          pat  <= r29_pat;
          len  <= r29_len;
          word <= r29_word;
          idx  <= '0;
          if (r29_len == '0 || r29_len > LEN_W'(MAX_ELEM)) state <= S_ERR;
          else                                             state <= S_MARK;
        end
        S_MARK: if (tmr_done) begin
          if (idx == len - 3'd1) state <= S_GAP;
          else                   state <= S_SPACE;
        end
        S_SPACE: if (tmr_done) begin
          idx   <= idx + 3'd1;
          state <= S_MARK;
        end
        S_GAP:      if (tmr_done) state <= S_DONE;
        S_DONE:     state <= S_WAIT_CLR;
        S_ERR:      state <= S_WAIT_CLR;
        S_WAIT_CLR: if (!r29_go) state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end
endmodule
